wb_sdram_bridge: RTL and testbench

Wishbone slave front-end that sits directly upstream of the SDRAM controller. It converts Caravel Wishbone word accesses into the controller's single-request user interface: in_valid/rw/user_addr/data_in in, busy/out_valid/data_out back. It holds one 8-word read line buffer. Read hits are acked without touching SDRAM. A read miss issues one line-aligned read and captures the controller's 8-pulse out_valid burst.

---
 rtl/wb_sdram_bridge.sv | 236 +++++++++++++++++++++++
 tb/tb_wb_sdram_bridge.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sdram_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_sdram_bridge: Wishbone slave in front of the SDRAM controller, with a  |
// | one-line read buffer filled by line-aligned controller bursts.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module wb_sdram_bridge #(
  parameter logic [31:0] BASE_ADDR    = 32'h3800_0000,
  parameter logic [31:0] ADDR_MASK    = 32'hFF80_0000,
  parameter int unsigned LINE_WORDS   = 8,
  parameter logic [15:0] FILL_TIMEOUT = 16'd64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        ctrl_in_valid,
  output logic        ctrl_rw,
  output logic [22:0] ctrl_addr,
  output logic [31:0] ctrl_data_in,
  input  logic        ctrl_busy,
  input  logic        ctrl_out_valid,
  input  logic [31:0] ctrl_data_out,
  output logic        fill_err
);

  localparam int c_IDX_W = $clog2(LINE_WORDS);
  localparam int c_TAG_W = 21 - c_IDX_W;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_ISSUE = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_FILL     = 3'd3,
    S_ACK      = 3'd4
  } state_t;

  state_t                r_state, w_state_nx;
  logic                  r_line_valid, w_line_valid_nx;
  logic [LINE_WORDS-1:0] r_word_valid, w_word_valid_nx;
  logic [c_TAG_W-1:0]    r_tag, w_tag_nx;
  logic [c_IDX_W-1:0]    r_idx, w_idx_nx;
  logic [c_IDX_W-1:0]    r_fill_cnt, w_fill_cnt_nx;
  logic [15:0]           r_tmo, w_tmo_nx;
  logic                  r_fill_err, w_fill_err_nx;
  logic                  r_acked, w_acked_nx;
  logic [31:0]           r_rdata, w_rdata_nx;
  logic                  r_ack, w_ack_nx;
  logic [31:0]           r_dat, w_dat_nx;
  logic                  r_in_valid, w_in_valid_nx;
  logic                  r_rw, w_rw_nx;
  logic [22:0]           r_addr, w_addr_nx;
  logic [31:0]           r_data_in, w_data_in_nx;
  logic [31:0]           r_buf [LINE_WORDS];
  logic                  w_buf_we;
  logic [c_IDX_W-1:0]    w_buf_wi;
  logic [31:0]           w_buf_wd;

  logic               w_req;
  logic [c_TAG_W-1:0] w_tag;
  logic [c_IDX_W-1:0] w_idx;
  logic               w_tag_match;
  logic               w_unused;

  // A request is ignored while ack is high so a still-held stb is not re-served.
  assign w_req       = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR) & ~r_ack;
  assign w_tag       = wbs_adr_i[22:c_IDX_W+2];
  assign w_idx       = wbs_adr_i[c_IDX_W+1:2];
  assign w_tag_match = r_line_valid & (r_tag == w_tag);
  assign w_unused    = ^wbs_sel_i;

  always_comb begin
    w_state_nx      = r_state;
    w_line_valid_nx = r_line_valid;
    w_word_valid_nx = r_word_valid;
    w_tag_nx        = r_tag;
    w_idx_nx        = r_idx;
    w_fill_cnt_nx   = r_fill_cnt;
    w_tmo_nx        = r_tmo;
    w_fill_err_nx   = r_fill_err;
    w_acked_nx      = r_acked;
    w_rdata_nx      = r_rdata;
    w_ack_nx        = 1'b0;
    w_dat_nx        = '0;
    w_in_valid_nx   = 1'b0;
    w_rw_nx         = r_rw;
    w_addr_nx       = r_addr;
    w_data_in_nx    = r_data_in;
    w_buf_we        = 1'b0;
    w_buf_wi        = r_fill_cnt;
    w_buf_wd        = ctrl_data_out;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_idx_nx = w_idx;
          if (wbs_we_i) begin
            w_rw_nx      = 1'b1;
            w_addr_nx    = {wbs_adr_i[22:2], 2'b00};
            w_data_in_nx = wbs_dat_i;
            w_rdata_nx   = '0;
            w_state_nx   = S_WR_ISSUE;
            // Write-through keeps the buffered line coherent with SDRAM.
            if (w_tag_match) begin
              w_buf_we = 1'b1;
              w_buf_wi = w_idx;
              w_buf_wd = wbs_dat_i;
            end
          end else if (w_tag_match) begin
            w_rdata_nx = r_buf[w_idx];
            w_state_nx = S_ACK;
          end else begin
            w_rw_nx         = 1'b0;
            w_addr_nx       = {w_tag, {(c_IDX_W+2){1'b0}}};
            w_line_valid_nx = 1'b0;
            w_word_valid_nx = '0;
            w_tag_nx        = w_tag;
            w_state_nx      = S_RD_ISSUE;
          end
        end
      end
      S_WR_ISSUE, S_RD_ISSUE: begin
        if (!ctrl_busy) begin
          w_in_valid_nx = 1'b1;
          if (r_state == S_RD_ISSUE) begin
            w_fill_cnt_nx = '0;
            w_tmo_nx      = '0;
            w_acked_nx    = 1'b0;
            w_state_nx    = S_FILL;
          end else begin
            w_state_nx = S_ACK;
          end
        end
      end
      S_FILL: begin
        w_tmo_nx = r_tmo + 16'd1;
        if (ctrl_out_valid) begin
          w_buf_we                    = 1'b1;
          w_word_valid_nx[r_fill_cnt] = 1'b1;
          w_fill_cnt_nx               = r_fill_cnt + 1'b1;
          // Early ack as soon as the requested word lands.
          if (!r_acked && w_word_valid_nx[r_idx]) begin
            w_ack_nx   = 1'b1;
            w_dat_nx   = ctrl_data_out;
            w_acked_nx = 1'b1;
          end
        end
        if (ctrl_out_valid && (r_fill_cnt == c_LAST_IDX)) begin
          w_line_valid_nx = 1'b1;
          w_state_nx      = S_IDLE;
        end else if (w_tmo_nx == FILL_TIMEOUT) begin
          w_fill_err_nx   = 1'b1;
          w_line_valid_nx = 1'b0;
          w_state_nx      = S_IDLE;
          if (!w_acked_nx) begin
            w_ack_nx   = 1'b1;
            w_dat_nx   = '0;
            w_acked_nx = 1'b1;
          end
        end
      end
      S_ACK: begin
        w_ack_nx   = 1'b1;
        w_dat_nx   = r_rdata;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_line_valid <= 1'b0;
      r_word_valid <= '0;
      r_tag        <= '0;
      r_idx        <= '0;
      r_fill_cnt   <= '0;
      r_tmo        <= '0;
      r_fill_err   <= 1'b0;
      r_acked      <= 1'b0;
      r_rdata      <= '0;
      r_ack        <= 1'b0;
      r_dat        <= '0;
      r_in_valid   <= 1'b0;
      r_rw         <= 1'b0;
      r_addr       <= '0;
      r_data_in    <= '0;
    end else begin
      r_line_valid <= w_line_valid_nx;
      r_word_valid <= w_word_valid_nx;
      r_tag        <= w_tag_nx;
      r_idx        <= w_idx_nx;
      r_fill_cnt   <= w_fill_cnt_nx;
      r_tmo        <= w_tmo_nx;
      r_fill_err   <= w_fill_err_nx;
      r_acked      <= w_acked_nx;
      r_rdata      <= w_rdata_nx;
      r_ack        <= w_ack_nx;
      r_dat        <= w_dat_nx;
      r_in_valid   <= w_in_valid_nx;
      r_rw         <= w_rw_nx;
      r_addr       <= w_addr_nx;
      r_data_in    <= w_data_in_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_buf_we) begin
      r_buf[w_buf_wi] <= w_buf_wd;
    end
  end

  assign wbs_ack_o     = r_ack;
  assign wbs_dat_o     = r_dat;
  assign ctrl_in_valid = r_in_valid;
  assign ctrl_rw       = r_rw;
  assign ctrl_addr     = r_addr;
  assign ctrl_data_in  = r_data_in;
  assign fill_err      = r_fill_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_sdram_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_sdram_bridge: scoreboard bench with a small SDRAM controller model. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_wb_sdram_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        ctrl_in_valid, ctrl_rw;
  logic [22:0] ctrl_addr;
  logic [31:0] ctrl_data_in;
  logic        ctrl_busy;
  logic        ctrl_out_valid;
  logic [31:0] ctrl_data_out;
  logic        fill_err;

  always #5 clk = ~clk;

  wb_sdram_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .ctrl_in_valid(ctrl_in_valid), .ctrl_rw(ctrl_rw), .ctrl_addr(ctrl_addr),
    .ctrl_data_in(ctrl_data_in), .ctrl_busy(ctrl_busy),
    .ctrl_out_valid(ctrl_out_valid), .ctrl_data_out(ctrl_data_out),
    .fill_err(fill_err)
  );

  typedef struct packed {
    logic        rw;
    logic [22:0] addr;
    logic [31:0] data;
  } req_t;

  logic [31:0] exp_ack_q[$];
  req_t        exp_req_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pulse = 0;
  logic        prev_iv = 1'b0;

  int          burst_len  = 8;
  int          burst_gap  = 0;
  logic [31:0] burst_base = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic rw, input logic [22:0] addr, input logic [31:0] data);
    req_t r;
    r.rw = rw; r.addr = addr; r.data = data;
    exp_req_q.push_back(r);
  endtask

  // Monitor: every ack and every controller request is popped against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wbs_ack_o) begin
        if (exp_ack_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_ack: got ack data %h, expected no ack", wbs_dat_o);
        end else begin
          check("ack_data", wbs_dat_o, exp_ack_q.pop_front());
        end
      end
      if (ctrl_in_valid) begin
        n_pulse++;
        if (exp_req_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_req: got addr %h rw %0d, expected no request", ctrl_addr, ctrl_rw);
        end else begin
          req_t e;
          e = exp_req_q.pop_front();
          check("req_rw", {31'd0, ctrl_rw}, {31'd0, e.rw});
          check("req_addr", {9'd0, ctrl_addr}, {9'd0, e.addr});
          if (e.rw) check("req_data", ctrl_data_in, e.data);
        end
        check("req_not_while_busy", {31'd0, ctrl_busy}, 32'd0);
        check("req_single_cycle", {31'd0, prev_iv}, 32'd0);
      end
      prev_iv = ctrl_in_valid;
    end else begin
      prev_iv = 1'b0;
    end
  end

  // Controller model: a read request triggers burst_len strobes of burst_base + i.
  initial begin
    ctrl_out_valid = 1'b0;
    ctrl_data_out  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && ctrl_in_valid && !ctrl_rw) begin
        for (int i = 0; i < burst_len; i++) begin
          @(posedge clk); #1;
          ctrl_out_valid = 1'b1;
          ctrl_data_out  = burst_base + i;
          @(posedge clk); #1;
          ctrl_out_valid = 1'b0;
          ctrl_data_out  = '0;
          for (int g = 0; g < burst_gap; g++) @(posedge clk);
        end
      end
    end
  end

  task automatic wb_req(input logic we, input logic [31:0] adr, input logic [31:0] dat, output int lat);
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = 4'hF;
    lat = 0;
    while (!wbs_ack_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!wbs_ack_o) begin
      n_cmp++; n_err++;
      $display("FAIL ack_timeout: got no ack for adr %h after %0d cycles, expected an ack", adr, lat);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"}, {31'd0, wbs_ack_o}, 32'd0);
    check({tag, "_dat"}, wbs_dat_o, 32'd0);
    check({tag, "_in_valid"}, {31'd0, ctrl_in_valid}, 32'd0);
    check({tag, "_rw"}, {31'd0, ctrl_rw}, 32'd0);
    check({tag, "_addr"}, {9'd0, ctrl_addr}, 32'd0);
    check({tag, "_data_in"}, ctrl_data_in, 32'd0);
    check({tag, "_fill_err"}, {31'd0, fill_err}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int p0;
    rst_n = 1'b0; ctrl_busy = 1'b0;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
    repeat (3) @(posedge clk); #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: posted write, ack one cycle after the issue pulse
    p0 = n_pulse;
    push_req(1'b1, 23'h000104, 32'hDEAD_BEEF);
    exp_ack_q.push_back(32'h0);
    wb_req(1'b1, 32'h3800_0104, 32'hDEAD_BEEF, lat);
    check("t1_write_latency", lat, 3);
    repeat (4) @(posedge clk); #1;
    check("t1_pulse_count", n_pulse - p0, 1);

    // 2: cold read miss, early ack on the third strobe
    burst_len = 8; burst_gap = 0; burst_base = 32'h100;
    push_req(1'b0, 23'h000100, 32'h0);
    exp_ack_q.push_back(32'h102);
    wb_req(1'b0, 32'h3800_0108, 32'h0, lat);
    repeat (12) @(posedge clk);

    // 3: hit on the filled line
    p0 = n_pulse;
    exp_ack_q.push_back(32'h107);
    wb_req(1'b0, 32'h3800_011C, 32'h0, lat);
    check("t3_hit_latency", lat, 2);
    repeat (2) @(posedge clk); #1;
    check("t3_no_request", n_pulse - p0, 0);

    // 4: write-through then read back from the buffer
    p0 = n_pulse;
    push_req(1'b1, 23'h000110, 32'h55);
    exp_ack_q.push_back(32'h0);
    wb_req(1'b1, 32'h3800_0110, 32'h55, lat);
    repeat (2) @(posedge clk);
    exp_ack_q.push_back(32'h55);
    wb_req(1'b0, 32'h3800_0110, 32'h0, lat);
    check("t4_readback_latency", lat, 2);
    repeat (2) @(posedge clk); #1;
    check("t4_one_write", n_pulse - p0, 1);

    // 5: controller busy holds the write issue
    @(posedge clk); #1;
    ctrl_busy = 1'b1;
    p0 = n_pulse;
    push_req(1'b1, 23'h000120, 32'hA5A5_0005);
    exp_ack_q.push_back(32'h0);
    fork
      wb_req(1'b1, 32'h3800_0120, 32'hA5A5_0005, lat);
      begin
        repeat (10) @(posedge clk); #1;
        check("t5_held_while_busy", n_pulse - p0, 0);
        ctrl_busy = 1'b0;
        @(posedge clk); #1;
        check("t5_pulse_after_busy", {31'd0, ctrl_in_valid}, 32'd1);
      end
    join
    repeat (2) @(posedge clk);

    // Outside the decode window: never acked, never issued
    p0 = n_pulse;
    @(posedge clk); #1;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h3880_0000;
    repeat (8) @(posedge clk); #1;
    check("miss_window_ack", {31'd0, wbs_ack_o}, 32'd0);
    wbs_cyc_i = 0; wbs_stb_i = 0;
    check("miss_window_req", n_pulse - p0, 0);

    // 6: short burst hits the fill timeout
    burst_len = 3; burst_base = 32'h200;
    push_req(1'b0, 23'h000200, 32'h0);
    exp_ack_q.push_back(32'h0);
    wb_req(1'b0, 32'h3800_0214, 32'h0, lat);
    check("t6_timeout_latency", lat, 66);
    check("t6_fill_err", {31'd0, fill_err}, 32'd1);
    repeat (2) @(posedge clk);
    burst_len = 8; burst_base = 32'h280;
    push_req(1'b0, 23'h000200, 32'h0);
    exp_ack_q.push_back(32'h285);
    wb_req(1'b0, 32'h3800_0214, 32'h0, lat);
    repeat (12) @(posedge clk);

    // Reset in the middle of a fill; late strobes must be ignored
    burst_len = 8; burst_gap = 2; burst_base = 32'h300;
    push_req(1'b0, 23'h000300, 32'h0);
    @(posedge clk); #1;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h3800_031C;
    repeat (10) @(posedge clk); #1;
    rst_n = 1'b0; wbs_cyc_i = 0; wbs_stb_i = 0;
    @(posedge clk); #1;
    check_outputs_zero("midfill_reset");
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    burst_gap = 0; burst_base = 32'h400;
    push_req(1'b0, 23'h000300, 32'h0);
    exp_ack_q.push_back(32'h407);
    wb_req(1'b0, 32'h3800_031C, 32'h0, lat);
    repeat (12) @(posedge clk); #1;

    check("pending_acks", exp_ack_q.size(), 0);
    check("pending_reqs", exp_req_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
